// File: rtl/apb_mem_pkg.sv
// Shared types and address-decode helpers for the APB memory slave.
package apb_mem_pkg;

  // Wait-state counter width; it covers 0..255 programmed wait states.
  localparam int WAIT_CNT_W = 8;

  // Transfer state: IDLE (waiting for SETUP) or ACCESS (data phase).
  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  // Decoded byte address. idx is kept wide so the range check sees every bit.
  typedef struct packed {
    logic [63:0] idx;
    logic        err;
  } decode_t;

  // Number of byte-offset bits below the word index.
  function automatic int lsb_of(input int data_w);
    return $clog2(data_w / 8);
  endfunction

  // Word-index width needed to address DEPTH entries (at least one bit).
  function automatic int mem_aw_of(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Split a byte address into a word index and flag misaligned or out-of-range access.
  function automatic decode_t addr_decode(input logic [63:0] addr, input int lsb, input int depth);
    decode_t     d;
    logic [63:0] mask;
    mask  = (64'd1 << lsb) - 64'd1;
    d.idx = addr >> lsb;
    d.err = (d.idx >= 64'(depth)) || ((addr & mask) != 64'd0);
    return d;
  endfunction

endpackage

// File: rtl/apb_mem_array.sv
// DEPTH x DATA_W word storage: synchronous byte-enable write, asynchronous read.
// Contents are deliberately not reset.
module apb_mem_array #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64,
  parameter int AW     = 6
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [DATA_W/8-1:0]   i_be,
  input  logic [AW-1:0]         i_addr,
  input  logic [DATA_W-1:0]     i_wdata,
  output logic [DATA_W-1:0]     o_rdata
);

  localparam int NB = DATA_W / 8;

  logic [DATA_W-1:0] r_mem [DEPTH];

  // Byte-lane write: only lanes with their enable set are updated.
  always_ff @(posedge clk) begin
    for (int b = 0; b < NB; b++) begin
      if (i_we && i_be[b]) begin
        r_mem[i_addr][b*8 +: 8] <= i_wdata[b*8 +: 8];
      end
    end
  end

  assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/apb_mem_slave.sv
// APB slave fronting a word memory, with programmable wait states and pslverr
// on misaligned or out-of-range addresses.
// Optional feature: define APB_MEM_PSTRB_EN to add the pstrb byte-strobe port.
module apb_mem_slave
  import apb_mem_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 64,
  parameter int WAIT_CYCLES = 0
) (
  input  logic                pclk,
  input  logic                prst_n,
  input  logic                psel,
  input  logic                penable,
  input  logic                pwrite,
  input  logic [ADDR_W-1:0]   paddr,
  input  logic [DATA_W-1:0]   pwdata,
`ifdef APB_MEM_PSTRB_EN
  input  logic [DATA_W/8-1:0] pstrb,
`endif
  output logic [DATA_W-1:0]   prdata,
  output logic                pready,
  output logic                pslverr
);

  localparam int LSB    = lsb_of(DATA_W);
  localparam int MEM_AW = mem_aw_of(DEPTH);
  localparam int NB     = DATA_W / 8;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [WAIT_CNT_W-1:0]   r_wait_cnt;
  logic                    r_err;
  logic [DATA_W-1:0]       r_prdata;
  logic [DATA_W-1:0]       w_rdata;
  decode_t                 w_dec;
  logic [MEM_AW-1:0]       w_mem_idx;
  logic [NB-1:0]           w_be;
  logic                    w_pready;
  logic                    w_load;
  logic                    w_dec_cnt;
  logic                    w_wr_en;

  assign w_dec     = addr_decode(64'(paddr), LSB, DEPTH);
  assign w_mem_idx = MEM_AW'(w_dec.idx);

`ifdef APB_MEM_PSTRB_EN
  assign w_be = pstrb;
`else
  assign w_be = {NB{1'b1}};
`endif

  assign w_pready = (r_state == ACCESS) && (r_wait_cnt == {WAIT_CNT_W{1'b0}});

  // State register.
  always_ff @(posedge pclk or negedge prst_n) begin
    if (!prst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state plus the load / count-down / write strobes for the datapath.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_dec_cnt   = 1'b0;
    w_wr_en     = 1'b0;
    case (r_state)
      IDLE: begin
        if (psel && !penable) begin
          w_state_nxt = ACCESS;
          w_load      = 1'b1;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      ACCESS: begin
        if (psel && penable) begin
          if (w_pready) begin
            w_state_nxt = IDLE;
            w_wr_en     = pwrite && !r_err;
          end else begin
            w_state_nxt = ACCESS;
            w_dec_cnt   = 1'b1;
          end
        end else if (psel) begin
          // A fresh SETUP mid-access restarts the transfer from scratch.
          w_state_nxt = ACCESS;
          w_load      = 1'b1;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Wait counter, latched error and read data captured at transfer entry.
  always_ff @(posedge pclk or negedge prst_n) begin
    if (!prst_n) begin
      r_wait_cnt <= {WAIT_CNT_W{1'b0}};
      r_err      <= 1'b0;
      r_prdata   <= {DATA_W{1'b0}};
    end else if (w_load) begin
      r_wait_cnt <= WAIT_CNT_W'(WAIT_CYCLES);
      r_err      <= w_dec.err;
      if (!pwrite) begin
        r_prdata <= w_dec.err ? {DATA_W{1'b0}} : w_rdata;
      end
    end else if (w_dec_cnt) begin
      r_wait_cnt <= r_wait_cnt - {{(WAIT_CNT_W-1){1'b0}}, 1'b1};
    end
  end

  apb_mem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (MEM_AW)
  ) u_mem (
    .clk     (pclk),
    .i_we    (w_wr_en),
    .i_be    (w_be),
    .i_addr  (w_mem_idx),
    .i_wdata (pwdata),
    .o_rdata (w_rdata)
  );

  assign prdata  = r_prdata;
  assign pready  = w_pready;
  assign pslverr = w_pready && r_err;

endmodule

// File: tb/tb_apb_mem_slave.sv
// Scoreboard bench for apb_mem_slave: stimulus pushes expected responses,
// a negedge monitor pops and compares on every completed transfer.
module tb_apb_mem_slave;

  localparam int ADDR_W = 9;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 64;
  localparam int WAIT   = 2;

  logic        pclk = 1'b0;
  logic        prst_n = 1'b0;
  logic        psel = 1'b0;
  logic        penable = 1'b0;
  logic        pwrite = 1'b0;
  logic [8:0]  paddr = 9'd0;
  logic [31:0] pwdata = 32'd0;
`ifdef APB_MEM_PSTRB_EN
  logic [3:0]  pstrb = 4'd0;
`endif
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  apb_mem_slave #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .WAIT_CYCLES(WAIT)
  ) dut (
    .pclk(pclk), .prst_n(prst_n), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata),
`ifdef APB_MEM_PSTRB_EN
    .pstrb(pstrb),
`endif
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  always #5 pclk = ~pclk;

  typedef struct {
    bit          wr;
    logic [31:0] rdata;
    bit          err;
  } exp_t;

  exp_t        q[$];
  logic [31:0] model [DEPTH];
  logic [31:0] last_rd = 32'd0;
  int          n_checks = 0;
  int          n_fails = 0;
  int          wait_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit is_err(input logic [8:0] a);
    return ((int'(a) % 4) != 0) || ((int'(a) / 4) >= DEPTH);
  endfunction

  // Drive SETUP signals and update the reference model (prdata loads at SETUP for reads).
  task automatic setup(input bit wr, input logic [8:0] a, input logic [31:0] d, input logic [3:0] s);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
`ifdef APB_MEM_PSTRB_EN
    pstrb = s;
`endif
    if (!wr) last_rd = is_err(a) ? 32'd0 : model[int'(a) / 4];
  endtask

  // Full transfer; call just after a rising edge; leaves bus idle unless chained.
  task automatic xfer(input bit wr, input logic [8:0] a, input logic [31:0] d, input logic [3:0] s);
    exp_t       e;
    bit         done;
    logic [3:0] s_eff;
`ifdef APB_MEM_PSTRB_EN
    s_eff = s;
`else
    s_eff = 4'hF;
`endif
    setup(wr, a, d, s);
    e.wr = wr; e.err = is_err(a); e.rdata = last_rd;
    q.push_back(e);
    if (wr && !is_err(a)) begin
      for (int b = 0; b < 4; b++)
        if (s_eff[b]) model[int'(a) / 4][b*8 +: 8] = d[b*8 +: 8];
    end
    @(posedge pclk); #1 penable = 1'b1;
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge pclk);
      done = pready;
    end
    n_checks++;
    if (!done) begin
      n_fails++;
      $display("FAIL timeout: pready got 0 expected 1 at %0t", $time);
    end
    @(posedge pclk); #1 psel = 1'b0; penable = 1'b0;
  endtask

  // Monitor: compare completed transfers, count wait states, check idle outputs.
  always @(negedge pclk) begin
    exp_t e;
    if (prst_n) begin
      if (psel && penable) begin
        if (pready) begin
          if (q.size() == 0) begin
            n_checks++; n_fails++;
            $display("FAIL unexpected_completion: got pready 1 expected no transfer at %0t", $time);
          end else begin
            e = q.pop_front();
            check("pslverr", 32'(pslverr), 32'(e.err));
            check(e.wr ? "prdata_hold" : "prdata", prdata, e.rdata);
            check("wait_states", 32'(wait_seen), 32'(WAIT));
          end
          wait_seen = 0;
        end else begin
          wait_seen++;
        end
      end else begin
        wait_seen = 0;
        if (!psel) begin
          check("idle_pready", 32'(pready), 32'd0);
          check("idle_pslverr", 32'(pslverr), 32'd0);
        end
      end
    end
  end

  initial begin
    logic [8:0]  a;
    logic [31:0] d;
    // Reset state.
    prst_n = 1'b0;
    repeat (3) @(posedge pclk);
    #1;
    check("reset_pready", 32'(pready), 32'd0);
    check("reset_pslverr", 32'(pslverr), 32'd0);
    check("reset_prdata", prdata, 32'd0);
    prst_n = 1'b1;
    @(posedge pclk); #1;

    // Fill every word so later reads are defined (back-to-back, no idle gap).
    for (int i = 0; i < DEPTH; i++) xfer(1'b1, 9'(i * 4), $urandom, 4'hF);

    // Basic write/read.
    xfer(1'b1, 9'h008, 32'h12345678, 4'hF);
    xfer(1'b0, 9'h008, 32'h0, 4'h0);

    // Errors: misaligned and out of range, reads then writes that must not land.
    xfer(1'b0, 9'h002, 32'h0, 4'h0);
    xfer(1'b0, 9'h100, 32'h0, 4'h0);
    xfer(1'b1, 9'h002, 32'hCAFEF00D, 4'hF);
    xfer(1'b1, 9'h100, 32'hCAFEF00D, 4'hF);
    xfer(1'b0, 9'h000, 32'h0, 4'h0);

    // Abort: psel dropped during a wait state; no write.
    setup(1'b1, 9'h00C, 32'hBAD0BAD0, 4'hF);
    @(posedge pclk); #1 penable = 1'b1;
    @(posedge pclk); #1 psel = 1'b0; penable = 1'b0;
    @(posedge pclk); #1;
    xfer(1'b0, 9'h00C, 32'h0, 4'h0);

    // Restart: new SETUP during ACCESS reloads the counter; first write discarded.
    setup(1'b1, 9'h010, 32'hBAD1BAD1, 4'hF);
    @(posedge pclk); #1 penable = 1'b1;
    @(posedge pclk); #1;
    xfer(1'b0, 9'h010, 32'h0, 4'h0);

    // Reset in the middle of a write's ACCESS phase.
    setup(1'b1, 9'h004, 32'hDEADBEEF, 4'hF);
    @(posedge pclk); #1 penable = 1'b1;
    @(negedge pclk); #2 prst_n = 1'b0;
    #1;
    check("midreset_pready", 32'(pready), 32'd0);
    check("midreset_prdata", prdata, 32'd0);
    psel = 1'b0; penable = 1'b0; last_rd = 32'd0;
    @(posedge pclk); #1 prst_n = 1'b1;
    @(posedge pclk); #1;
    xfer(1'b0, 9'h004, 32'h0, 4'h0);

`ifdef APB_MEM_PSTRB_EN
    xfer(1'b1, 9'h014, 32'hAABBCCDD, 4'hF);
    xfer(1'b1, 9'h014, 32'h11223344, 4'b0101);
    xfer(1'b0, 9'h014, 32'h0, 4'h0);
    check("strobe_model", model[5], 32'hAA22CC44);
    xfer(1'b1, 9'h014, 32'h55555555, 4'b0000);
    xfer(1'b0, 9'h014, 32'h0, 4'h0);
`endif

    // Randomized traffic: mostly legal aligned addresses, some arbitrary.
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 9) < 7) a = 9'($urandom_range(0, DEPTH - 1) * 4);
      else                          a = 9'($urandom_range(0, 511));
      d = $urandom;
      xfer(1'($urandom_range(0, 1)), a, d, 4'($urandom_range(0, 15)));
      if ($urandom_range(0, 4) == 0) begin
        @(posedge pclk); #1;
      end
    end

    repeat (4) @(posedge pclk);
    check("queue_drained", 32'(q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
